// File: rtl/jala_pkg.sv
// Shared constants and state type for the program loader.
package jala_pkg;

    localparam int DATA_W        = 16;
    localparam int ADDR_W_DEF    = 14;
    localparam int MEM_DEPTH_DEF = 10240;
    localparam int RST_HOLD_DEF  = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        ERR
    } loader_state_t;

    // Counter width able to hold a reset-hold value (at least one bit).
    function automatic int holdWidth(input int hold);
        return (hold < 2) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/rst_hold_timer.sv
// Down-counter that keeps the CPU in reset for a fixed number of cycles
// after the last instruction word has been written.
module rst_hold_timer #(
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             RstN,
    input  logic             load,
    input  logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge CLK) begin
        if (!RstN) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= count;
        end else if (remaining != '0) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Asserted in the cycle whose edge takes the count to zero, so the owner leaves HOLD on that edge.
    assign expired = (remaining <= CNT_W'(1));

endmodule

// File: rtl/program_loader.sv
// Streams instruction words into memory and holds the CPU in reset until loading completes.
// Optional: define LOADER_CHECKSUM_EN to add a running Checksum of written words.
module program_loader #(
    parameter int DATA_W    = jala_pkg::DATA_W,
    parameter int ADDR_W    = jala_pkg::ADDR_W_DEF,
    parameter int MEM_DEPTH = jala_pkg::MEM_DEPTH_DEF,
    parameter int RST_HOLD  = jala_pkg::RST_HOLD_DEF
) (
    input  logic              CLK,
    input  logic              RstN,
    input  logic              Start,
    input  logic              InValid,
    input  logic [DATA_W-1:0] InData,
    input  logic              InLast,
    output logic              InReady,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemData,
    output logic              CpuRst,
    output logic [15:0]       MaxInstr,
    output logic              Busy,
    output logic              Done,
    output logic              Err
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] Checksum
`endif
);

    import jala_pkg::*;

    localparam int               HOLD_W    = holdWidth(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);
    localparam logic [15:0]      DEPTH     = 16'(MEM_DEPTH);

    loader_state_t state;
    loader_state_t stateNext;
    logic [15:0]   count;
    logic          doWrite;
    logic          clearCount;
    logic          holdLoad;
    logic          holdExpired;

    assign MaxInstr = count;

    always_ff @(posedge CLK) begin
        if (!RstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        InReady    = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        Err        = 1'b0;
        CpuRst     = 1'b1;
        doWrite    = 1'b0;
        clearCount = 1'b0;
        holdLoad   = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    stateNext  = LOAD;
                    clearCount = 1'b1;
                end
            end
            LOAD: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                // A beat arriving with memory already full is dropped and flags an error.
                if (InValid) begin
                    if (count < DEPTH) begin
                        doWrite = 1'b1;
                        if (InLast) begin
                            stateNext = HOLD;
                            holdLoad  = 1'b1;
                        end
                    end else begin
                        stateNext = ERR;
                    end
                end
            end
            HOLD: begin
                Busy = 1'b1;
                if (holdExpired) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                CpuRst = 1'b0;
                Done   = 1'b1;
                if (Start) begin
                    stateNext  = LOAD;
                    clearCount = 1'b1;
                end
            end
            ERR: begin
                Err = 1'b1;
                if (Start) begin
                    stateNext  = LOAD;
                    clearCount = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RstN) begin
            count   <= '0;
            MemWE   <= 1'b0;
            MemAddr <= '0;
            MemData <= '0;
        end else begin
            MemWE <= doWrite;
            if (clearCount) begin
                count <= '0;
            end else if (doWrite) begin
                count   <= count + 16'd1;
                MemAddr <= ADDR_W'(count);
                MemData <= InData;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (!RstN) begin
            Checksum <= '0;
        end else if (clearCount) begin
            Checksum <= '0;
        end else if (doWrite) begin
            Checksum <= Checksum + InData;
        end
    end
`else
    // No running sum of written words in this build.
`endif

    rst_hold_timer #(
        .CNT_W(HOLD_W)
    ) holdTimer (
        .CLK    (CLK),
        .RstN   (RstN),
        .load   (holdLoad),
        .count  (HOLD_INIT),
        .expired(holdExpired)
    );

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: memory writes are scoreboarded
// against expected address/data/cycle, status outputs are checked per scenario.
module tb_program_loader;

    localparam int BOUND = 20;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RstN;
    logic        Start, InValid, InLast;
    logic [15:0] InData;
    logic        InReady, MemWE, CpuRst, Busy, Done, Err;
    logic [13:0] MemAddr;
    logic [15:0] MemData, MaxInstr;
    logic        sStart, sInValid, sInLast;
    logic [15:0] sInData;
    logic        sInReady, sMemWE, sCpuRst, sBusy, sDone, sErr;
    logic [13:0] sMemAddr;
    logic [15:0] sMemData, sMaxInstr;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] Checksum, sChecksum;
`endif

    int  checks = 0;
    int  errors = 0;
    int  cycle  = 0;
    wr_t expMain[$];
    wr_t obsMain[$];
    wr_t expSmall[$];
    wr_t obsSmall[$];

    program_loader dut (
        .CLK(CLK), .RstN(RstN), .Start(Start),
        .InValid(InValid), .InData(InData), .InLast(InLast), .InReady(InReady),
        .MemWE(MemWE), .MemAddr(MemAddr), .MemData(MemData),
        .CpuRst(CpuRst), .MaxInstr(MaxInstr), .Busy(Busy), .Done(Done), .Err(Err)
`ifdef LOADER_CHECKSUM_EN
        , .Checksum(Checksum)
`endif
    );

    program_loader #(.MEM_DEPTH(4)) dutSmall (
        .CLK(CLK), .RstN(RstN), .Start(sStart),
        .InValid(sInValid), .InData(sInData), .InLast(sInLast), .InReady(sInReady),
        .MemWE(sMemWE), .MemAddr(sMemAddr), .MemData(sMemData),
        .CpuRst(sCpuRst), .MaxInstr(sMaxInstr), .Busy(sBusy), .Done(sDone), .Err(sErr)
`ifdef LOADER_CHECKSUM_EN
        , .Checksum(sChecksum)
`endif
    );

    initial forever #5 CLK = ~CLK;

    function automatic wr_t mkWr(input logic [15:0] a, input logic [15:0] d, input int c);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.cyc  = c;
        return w;
    endfunction

    // Advance one clock and record any memory write each DUT presents.
    task automatic tick();
        wr_t w;
        @(posedge CLK);
        #1;
        cycle++;
        if (MemWE === 1'b1) begin
            w = mkWr(16'(MemAddr), MemData, cycle);
            obsMain.push_back(w);
        end
        if (sMemWE === 1'b1) begin
            w = mkWr(16'(sMemAddr), sMemData, cycle);
            obsSmall.push_back(w);
        end
    endtask

    task automatic test_reset();
        RstN = 1'b0;
        tick();
        tick();
        checks++;
        if ({MemWE, InReady, Busy, Done, Err, CpuRst} !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000001", {MemWE, InReady, Busy, Done, Err, CpuRst});
        end
        checks++;
        if ({MaxInstr, MemAddr, MemData} !== 46'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got max %0h addr %0h data %0h expected all 0", MaxInstr, MemAddr, MemData);
        end
        checks++;
        if ({sMemWE, sInReady, sBusy, sDone, sErr, sCpuRst} !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL reset_small: got %b expected 000001", {sMemWE, sInReady, sBusy, sDone, sErr, sCpuRst});
        end
        RstN = 1'b1;
        tick();
        checks++;
        if ({InReady, Busy, CpuRst} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %b expected 001", {InReady, Busy, CpuRst});
        end
    endtask

    task automatic test_basic_load();
        wr_t e, o;
        int  n;
        InValid = 1'b1;
        InData  = 16'hDEAD;
        tick();
        InValid = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++;
        if ({InReady, Busy, CpuRst, Done} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL basic_load_state: got %b expected 1110", {InReady, Busy, CpuRst, Done});
        end
        for (int i = 0; i < 5; i++) begin
            InValid = 1'b1;
            InData  = 16'h1000 + 16'(i);
            InLast  = (i == 4);
            expMain.push_back(mkWr(16'(i), InData, cycle + 1));
            tick();
        end
        InValid = 1'b0;
        InLast  = 1'b0;
        checks++;
        if (MaxInstr !== 16'd5) begin
            errors++;
            $display("[TB] FAIL basic_maxinstr: got %0d expected 5", MaxInstr);
        end
        n = 0;
        while (CpuRst === 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("[TB] FAIL basic_hold: CpuRst fell after %0d cycles expected 3", n);
        end
        checks++;
        if ({Done, Busy, Err, CpuRst} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL basic_run: got %b expected 1000", {Done, Busy, Err, CpuRst});
        end
        while (expMain.size() > 0 && obsMain.size() > 0) begin
            e = expMain.pop_front();
            o = obsMain.pop_front();
            checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                errors++;
                $display("[TB] FAIL basic_write: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                         o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
            end
        end
        checks++;
        if (obsMain.size() != 0 || expMain.size() != 0) begin
            errors++;
            $display("[TB] FAIL basic_count: extra %0d missing %0d expected 0 0", obsMain.size(), expMain.size());
        end
        obsMain.delete();
        expMain.delete();
    endtask

    task automatic test_valid_toggle();
        wr_t         e, o;
        int          n;
        logic [15:0] addr;
        logic        acc;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++;
        if ({CpuRst, MaxInstr} !== {1'b1, 16'd0}) begin
            errors++;
            $display("[TB] FAIL toggle_restart: got cpurst %b max %0d expected 1 0", CpuRst, MaxInstr);
        end
        addr = 16'd0;
        for (int i = 0; i < 12; i++) begin
            acc     = (i % 2 == 0);
            InValid = acc || (i == 11);
            InData  = 16'h2000 + 16'(i);
            InLast  = (i == 10);
            if (acc) begin
                expMain.push_back(mkWr(addr, InData, cycle + 1));
                addr++;
            end
            tick();
        end
        InValid = 1'b0;
        InLast  = 1'b0;
        checks++;
        if (MaxInstr !== 16'd6) begin
            errors++;
            $display("[TB] FAIL toggle_maxinstr: got %0d expected 6", MaxInstr);
        end
        n = 0;
        while (CpuRst === 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 2 || Done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL toggle_hold: got %0d cycles done %b expected 2 1", n, Done);
        end
        while (expMain.size() > 0 && obsMain.size() > 0) begin
            e = expMain.pop_front();
            o = obsMain.pop_front();
            checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                errors++;
                $display("[TB] FAIL toggle_write: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                         o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
            end
        end
        checks++;
        if (obsMain.size() != 0 || expMain.size() != 0) begin
            errors++;
            $display("[TB] FAIL toggle_count: extra %0d missing %0d expected 0 0", obsMain.size(), expMain.size());
        end
        obsMain.delete();
        expMain.delete();
    endtask

    task automatic test_overflow();
        wr_t e, o;
        sStart = 1'b1;
        tick();
        sStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sInValid = 1'b1;
            sInData  = 16'h3000 + 16'(i);
            sInLast  = 1'b0;
            if (i < 4) begin
                expSmall.push_back(mkWr(16'(i), sInData, cycle + 1));
            end
            tick();
        end
        sInValid = 1'b0;
        checks++;
        if ({sErr, sCpuRst, sBusy, sDone, sInReady, sMemWE} !== 6'b110000) begin
            errors++;
            $display("[TB] FAIL overflow_flags: got %b expected 110000", {sErr, sCpuRst, sBusy, sDone, sInReady, sMemWE});
        end
        checks++;
        if (sMaxInstr !== 16'd4) begin
            errors++;
            $display("[TB] FAIL overflow_maxinstr: got %0d expected 4", sMaxInstr);
        end
        tick();
        tick();
        checks++;
        if (sErr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_persist: got err %b expected 1", sErr);
        end
        sStart = 1'b1;
        tick();
        sStart = 1'b0;
        checks++;
        if ({sErr, sBusy, sMaxInstr} !== {1'b0, 1'b1, 16'd0}) begin
            errors++;
            $display("[TB] FAIL overflow_restart: got err %b busy %b max %0d expected 0 1 0", sErr, sBusy, sMaxInstr);
        end
        while (expSmall.size() > 0 && obsSmall.size() > 0) begin
            e = expSmall.pop_front();
            o = obsSmall.pop_front();
            checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                errors++;
                $display("[TB] FAIL overflow_write: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                         o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
            end
        end
        checks++;
        if (obsSmall.size() != 0 || expSmall.size() != 0) begin
            errors++;
            $display("[TB] FAIL overflow_count: extra %0d missing %0d expected 0 0", obsSmall.size(), expSmall.size());
        end
        obsSmall.delete();
        expSmall.delete();
    endtask

    task automatic test_reset_mid_load();
        wr_t e, o;
        int  n;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            InValid = 1'b1;
            InData  = 16'h4000 + 16'(i);
            InLast  = 1'b0;
            expMain.push_back(mkWr(16'(i), InData, cycle + 1));
            tick();
        end
        InData = 16'h4002;
        RstN   = 1'b0;
        tick();
        RstN    = 1'b1;
        InValid = 1'b0;
        checks++;
        if ({MemWE, Busy, InReady, CpuRst, Done, Err} !== 6'b000100) begin
            errors++;
            $display("[TB] FAIL midreset_flags: got %b expected 000100", {MemWE, Busy, InReady, CpuRst, Done, Err});
        end
        checks++;
        if (MaxInstr !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_maxinstr: got %0d expected 0", MaxInstr);
        end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            InValid = 1'b1;
            InData  = 16'h4100 + 16'(i);
            InLast  = (i == 2);
            expMain.push_back(mkWr(16'(i), InData, cycle + 1));
            tick();
        end
        InValid = 1'b0;
        InLast  = 1'b0;
        n = 0;
        while (CpuRst === 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 3 || Done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_reload: got %0d cycles done %b expected 3 1", n, Done);
        end
        while (expMain.size() > 0 && obsMain.size() > 0) begin
            e = expMain.pop_front();
            o = obsMain.pop_front();
            checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                errors++;
                $display("[TB] FAIL midreset_write: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                         o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
            end
        end
        checks++;
        if (obsMain.size() != 0 || expMain.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_count: extra %0d missing %0d expected 0 0", obsMain.size(), expMain.size());
        end
        obsMain.delete();
        expMain.delete();
    endtask

    task automatic test_start_hold_run();
        wr_t e, o;
        int  n;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++;
        if ({CpuRst, Done, Busy, MaxInstr} !== {1'b1, 1'b0, 1'b1, 16'd0}) begin
            errors++;
            $display("[TB] FAIL run_restart: got cpurst %b done %b busy %b max %0d expected 1 0 1 0", CpuRst, Done, Busy, MaxInstr);
        end
        for (int i = 0; i < 2; i++) begin
            InValid = 1'b1;
            InData  = 16'h5000 + 16'(i);
            InLast  = (i == 1);
            expMain.push_back(mkWr(16'(i), InData, cycle + 1));
            tick();
        end
        Start   = 1'b1;
        InValid = 1'b1;
        InLast  = 1'b0;
        InData  = 16'hBEEF;
        tick();
        Start   = 1'b0;
        InValid = 1'b0;
        checks++;
        if ({Busy, CpuRst, MaxInstr} !== {1'b1, 1'b1, 16'd2}) begin
            errors++;
            $display("[TB] FAIL hold_start: got busy %b cpurst %b max %0d expected 1 1 2", Busy, CpuRst, MaxInstr);
        end
        n = 0;
        while (CpuRst === 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 2 || Done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_ignore: got %0d cycles done %b expected 2 1", n, Done);
        end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++;
        if ({CpuRst, Busy, Done, MaxInstr} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL run_start: got cpurst %b busy %b done %b max %0d expected 1 1 0 0", CpuRst, Busy, Done, MaxInstr);
        end
        InValid = 1'b1;
        InData  = 16'h5555;
        InLast  = 1'b1;
        expMain.push_back(mkWr(16'd0, InData, cycle + 1));
        tick();
        InValid = 1'b0;
        InLast  = 1'b0;
        n = 0;
        while (CpuRst === 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 3 || MaxInstr !== 16'd1) begin
            errors++;
            $display("[TB] FAIL run_reload: got %0d cycles max %0d expected 3 1", n, MaxInstr);
        end
        while (expMain.size() > 0 && obsMain.size() > 0) begin
            e = expMain.pop_front();
            o = obsMain.pop_front();
            checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                errors++;
                $display("[TB] FAIL holdrun_write: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                         o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
            end
        end
        checks++;
        if (obsMain.size() != 0 || expMain.size() != 0) begin
            errors++;
            $display("[TB] FAIL holdrun_count: extra %0d missing %0d expected 0 0", obsMain.size(), expMain.size());
        end
        obsMain.delete();
        expMain.delete();
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        wr_t e, o;
        int  n;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++;
        if (Checksum !== 16'd0) begin
            errors++;
            $display("[TB] FAIL checksum_clear: got %h expected 0000", Checksum);
        end
        for (int i = 0; i < 2; i++) begin
            InValid = 1'b1;
            InData  = (i == 0) ? 16'hFFFF : 16'h0002;
            InLast  = (i == 1);
            expMain.push_back(mkWr(16'(i), InData, cycle + 1));
            tick();
        end
        InValid = 1'b0;
        InLast  = 1'b0;
        checks++;
        if (Checksum !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL checksum_sum: got %h expected 0001", Checksum);
        end
        n = 0;
        while (CpuRst === 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        while (expMain.size() > 0 && obsMain.size() > 0) begin
            e = expMain.pop_front();
            o = obsMain.pop_front();
            checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                errors++;
                $display("[TB] FAIL checksum_write: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                         o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
            end
        end
        checks++;
        if (obsMain.size() != 0 || expMain.size() != 0 || n >= BOUND) begin
            errors++;
            $display("[TB] FAIL checksum_count: extra %0d missing %0d wait %0d expected 0 0 below %0d",
                     obsMain.size(), expMain.size(), n, BOUND);
        end
        obsMain.delete();
        expMain.delete();
    endtask
`endif

    initial begin
        RstN     = 1'b0;
        Start    = 1'b0;
        InValid  = 1'b0;
        InData   = 16'd0;
        InLast   = 1'b0;
        sStart   = 1'b0;
        sInValid = 1'b0;
        sInData  = 16'd0;
        sInLast  = 1'b0;
        test_reset();
        test_basic_load();
        test_valid_toggle();
        test_overflow();
        test_reset_mid_load();
        test_start_hold_run();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
